fft_band_energy: RTL and testbench

- Sits directly downstream of fft_core and consumes its output stream (dv, xk_index, xk_re, xk_im).
- Computes |X[k]|^2 = re^2 + im^2 for each bin in the lower half of the spectrum.
- Accumulates the results into NUM_BANDS equal-width frequency bands.
- Publishes a stable per-band energy vector once per completed frame, for the visualiser and beat logic.

---
 rtl/fft_band_energy_if.sv | 22 ++
 rtl/fft_band_energy.sv | 229 ++++++++++++++++++++++
 tb/tb_fft_band_energy.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_band_energy_if.sv
// fft_band_energy_if
//   Output stream of fft_core as seen by fft_band_energy: one spectral bin
//   per cycle while dv is high.
//
//   dv        sample valid; the bin is consumed on every cycle dv=1
//   xk_index  bin index, FFT_LOG2N bits
//   xk_re     signed 16-bit real part
//   xk_im     signed 16-bit imaginary part
//
//   master: the FFT side (drives the stream)
//   slave : the band-energy side (consumes the stream)
interface fft_band_energy_if #(
  parameter int FFT_LOG2N = 10
) ();
  logic                 dv;
  logic [FFT_LOG2N-1:0] xk_index;
  logic signed [15:0]   xk_re;
  logic signed [15:0]   xk_im;

  modport master (output dv, output xk_index, output xk_re, output xk_im);
  modport slave  (input  dv, input  xk_index, input  xk_re, input  xk_im);
endinterface

// File: rtl/fft_band_energy.sv
// fft_band_energy
//   Squares the magnitude of each lower-half FFT bin, accumulates the results
//   into NUM_BANDS equal-width bands and publishes the band vector once per
//   completed frame. A frame is the contiguous index run 0 .. 2^FFT_LOG2N-1;
//   dv may drop for any number of cycles inside a frame.
//
//   Optional feature: define BEAT_DETECT_EN to enable a band-0 beat detector
//   that compares each new frame against a running average.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   fft          stream input (dv, xk_index, xk_re, xk_im), slave modport
//   band_energy  published energies, band b at [b*ENERGY_W +: ENERGY_W]
//   frame_done   one-cycle pulse, band_energy updated the same cycle
//   frame_err    one-cycle pulse on an aborted or malformed frame
//   busy         a frame is in progress or the pipeline holds data
//   beat         one-cycle beat pulse (constant 0 without BEAT_DETECT_EN)
module fft_band_energy #(
  parameter  int FFT_LOG2N  = 10,
  parameter  int BANDS_LOG2 = 3,
  parameter  int ENERGY_W   = 40,
  localparam int NUM_BANDS  = 1 << BANDS_LOG2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  fft_band_energy_if.slave              fft,
  output logic [NUM_BANDS*ENERGY_W-1:0] band_energy,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          busy,
  output logic                          beat
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  localparam logic [FFT_LOG2N-1:0] IDX_ZERO = '0;
  localparam logic [FFT_LOG2N-1:0] IDX_ONE  = {{(FFT_LOG2N-1){1'b0}}, 1'b1};
  localparam logic [FFT_LOG2N-1:0] IDX_LAST = '1;

  logic [0:0]           state, state_nxt;
  logic [FFT_LOG2N-1:0] last_idx;

  // Sequence check decisions made on the raw input sample
  logic take, take_first, take_last, seq_err;

  // Stage 1: accepted sample
  logic                  s1_valid, s1_first, s1_last, s1_keep;
  logic [BANDS_LOG2-1:0] s1_band;
  logic signed [15:0]    s1_re, s1_im;

  // Stage 2: squared components
  logic                  s2_valid, s2_first, s2_last, s2_keep;
  logic [BANDS_LOG2-1:0] s2_band;
  logic signed [31:0]    s2_re2, s2_im2;

  // Stage 3: magnitude and accumulation
  logic [31:0]                   mag;
  logic [ENERGY_W-1:0]           mag_ext;
  logic [ENERGY_W-1:0]           acc     [NUM_BANDS];
  logic [ENERGY_W-1:0]           acc_nxt [NUM_BANDS];
  logic [NUM_BANDS*ENERGY_W-1:0] acc_pack;

  // ---------------------------------------------------------------------------
  // Frame sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement leaves a value held (which would be a latch).
    state_nxt  = state;
    take       = 1'b0;
    take_first = 1'b0;
    take_last  = 1'b0;
    seq_err    = 1'b0;
    if (fft.dv) begin
      case (state)
        ST_IDLE: begin
          // Anything other than bin 0 is ignored until a frame starts.
          if (fft.xk_index == IDX_ZERO) begin
            take       = 1'b1;
            take_first = 1'b1;
            state_nxt  = ST_ACCUM;
          end
        end
        default: begin
          if (fft.xk_index == last_idx + IDX_ONE) begin
            take = 1'b1;
            if (fft.xk_index == IDX_LAST) begin
              take_last = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (fft.xk_index == IDX_ZERO) begin
            // A fresh bin 0 mid-frame restarts the frame in place.
            seq_err    = 1'b1;
            take       = 1'b1;
            take_first = 1'b1;
          end else begin
            seq_err   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_idx  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= seq_err;
      if (take) last_idx <= fft.xk_index;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control (valids and frame markers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else begin
      s1_valid <= take;
      s1_first <= take_first;
      s1_last  <= take_last;
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  // NOTE: pure datapath registers carry no reset; the valid bits above decide
  // whether their contents are ever used.
  always_ff @(posedge clk) begin
    s1_keep <= ~fft.xk_index[FFT_LOG2N-1];
    s1_band <= fft.xk_index[FFT_LOG2N-2 -: BANDS_LOG2];
    s1_re   <= fft.xk_re;
    s1_im   <= fft.xk_im;
    s2_keep <= s1_keep;
    s2_band <= s1_band;
    s2_re2  <= s1_re * s1_re;
    s2_im2  <= s1_im * s1_im;
  end

  // ---------------------------------------------------------------------------
  // Magnitude and band accumulation
  // ---------------------------------------------------------------------------
  // Each square is at most 2^30, so the unsigned sum fits in 32 bits.
  assign mag     = $unsigned(s2_re2) + $unsigned(s2_im2);
  assign mag_ext = {{(ENERGY_W-32){1'b0}}, mag};

  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      // Bin 0 clears every band, so its own band ends up loaded with mag.
      acc_nxt[b] = (s2_valid && s2_first) ? '0 : acc[b];
      if (s2_valid && s2_keep && (s2_band == BANDS_LOG2'(b)))
        acc_nxt[b] = acc_nxt[b] + mag_ext;
    end
  end

  always_comb begin
    acc_pack = '0;
    for (int b = 0; b < NUM_BANDS; b++)
      acc_pack[b*ENERGY_W +: ENERGY_W] = acc_nxt[b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANDS; b++) acc[b] <= '0;
      band_energy <= '0;
      frame_done  <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANDS; b++) acc[b] <= acc_nxt[b];
      frame_done <= s2_valid && s2_last;
      // Publish includes the last bin's contribution, taken from acc_nxt.
      if (s2_valid && s2_last) band_energy <= acc_pack;
    end
  end

  assign busy = (state == ST_ACCUM) | s1_valid | s2_valid;

  // ---------------------------------------------------------------------------
  // Beat detector on band 0
  // ---------------------------------------------------------------------------
`ifdef BEAT_DETECT_EN
  logic [ENERGY_W-1:0]      avg;
  logic                     avg_seeded;
  logic [ENERGY_W-1:0]      e_band0;
  logic signed [ENERGY_W:0] avg_diff;
  logic signed [ENERGY_W:0] avg_step;

  assign e_band0  = band_energy[ENERGY_W-1:0];
  assign avg_diff = $signed({1'b0, e_band0}) - $signed({1'b0, avg});
  assign avg_step = avg_diff >>> 3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg        <= '0;
      avg_seeded <= 1'b0;
      beat       <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (frame_done) begin
        if (!avg_seeded) begin
          avg        <= e_band0;
          avg_seeded <= 1'b1;
        end else begin
          beat <= (avg != '0) && ({1'b0, e_band0} > {avg, 1'b0});
          // Modular add of the sign-extended step gives avg + (e-avg)/8.
          avg  <= avg + avg_step[ENERGY_W-1:0];
        end
      end
    end
  end
`else
  assign beat = 1'b0;
`endif

endmodule

// File: tb/tb_fft_band_energy.sv
// tb_fft_band_energy
//   Directed frames drive the stream; each expected frame_done / frame_err
//   event is queued by the stimulus and popped by an independent monitor.
module tb_fft_band_energy;

  localparam int LOG2N = 10;
  localparam int BL    = 3;
  localparam int EW    = 40;
  localparam int NB    = 1 << BL;
  localparam int BW    = NB * EW;
  localparam int NBINS = 1 << LOG2N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] band_energy;
  logic          frame_done, frame_err, busy, beat;

  fft_band_energy_if #(.FFT_LOG2N(LOG2N)) fif ();

  fft_band_energy #(
    .FFT_LOG2N (LOG2N),
    .BANDS_LOG2(BL),
    .ENERGY_W  (EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fft        (fif),
    .band_energy(band_energy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy),
    .beat       (beat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_err;
    logic [BW-1:0] bands;
    int            exp_cyc;
    logic          chk_beat;
    logic          exp_beat;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [BW-1:0] all_bands(input logic [EW-1:0] v);
    logic [BW-1:0] r;
    for (int b = 0; b < NB; b++) r[b*EW +: EW] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] one_band(input int band, input logic [EW-1:0] v);
    logic [BW-1:0] r;
    r = '0;
    r[band*EW +: EW] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic beat_pend = 1'b0;
  logic beat_exp  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      beat_pend = 1'b0;
    end else begin
      if (beat_pend) begin
        check("beat", BW'(beat), BW'(beat_exp));
        beat_pend = 1'b0;
      end
      if (frame_done || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: frame_done=%b frame_err=%b at cycle %0d, none expected",
                   frame_done, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", BW'({frame_done, frame_err}), BW'(e.is_err ? 2'b01 : 2'b10));
          check("event_cycle", BW'(cyc), BW'(e.exp_cyc));
          if (!e.is_err) check("bands", band_energy, e.bands);
          if (e.chk_beat) begin
            beat_pend = 1'b1;
            beat_exp  = e.exp_beat;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input int idx, input int re, input int im);
    @(posedge clk);
    #1;
    fif.dv       = 1'b1;
    fif.xk_index = idx[LOG2N-1:0];
    fif.xk_re    = re[15:0];
    fif.xk_im    = im[15:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      fif.dv = 1'b0;
    end
  endtask

  task automatic push_event(input logic is_err, input logic [BW-1:0] bands, input int lat,
                            input logic chk_beat, input logic exp_beat);
    exp_t e;
    e.is_err   = is_err;
    e.bands    = bands;
    e.exp_cyc  = cyc + lat;
    e.chk_beat = chk_beat;
    e.exp_beat = exp_beat;
    exp_q.push_back(e);
  endtask

  // Full frame: every bin carries (base_re, 0) except sp_bin with (sp_re, sp_im).
  task automatic run_frame(input int base_re, input int sp_bin, input int sp_re, input int sp_im,
                           input bit gaps, input logic [BW-1:0] exp_b,
                           input logic chk_beat, input logic exp_beat);
    for (int i = 0; i < NBINS; i++) begin
      if (i == sp_bin) drive(i, sp_re, sp_im);
      else             drive(i, base_re, 0);
      if (i == NBINS - 1) push_event(1'b0, exp_b, 3, chk_beat, exp_beat);
      else if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_queue_empty", BW'(exp_q.size()), '0);
  endtask

  task automatic do_reset();
    #1;
    rst_n  = 1'b0;
    fif.dv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    fif.dv       = 1'b0;
    fif.xk_index = '0;
    fif.xk_re    = '0;
    fif.xk_im    = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bands", band_energy, '0);
    check("reset_flags", BW'({frame_done, frame_err, busy, beat}), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A stray non-zero index while idle is dropped silently.
    drive(5, 100, 0);
    idle(2);
    check("idle_drop_busy", BW'(busy), '0);

    // Every bin re=1: each band collects 64 unit magnitudes.
    run_frame(1, -1, 0, 0, 1'b0, all_bands(40'd64), 1'b0, 1'b0);
    wait_drain();
    check("idle_after_frame", BW'(busy), '0);

    // Only an upper-half bin is non-zero: everything discarded.
    run_frame(0, 600, 1000, 0, 1'b0, all_bands(40'd0), 1'b0, 1'b0);
    wait_drain();

    // Bin 70 (band 1): 100^2 + (-100)^2 = 20000.
    run_frame(0, 70, 100, -100, 1'b0, one_band(1, 40'd20000), 1'b0, 1'b0);
    wait_drain();

    // Sequence break 0..5 then 9: one frame_err, published values held.
    for (int i = 0; i <= 5; i++) drive(i, 7, 0);
    drive(9, 7, 0);
    push_event(1'b1, '0, 1, 1'b0, 1'b0);
    idle(1);
    wait_drain();
    check("abort_hold", band_energy, one_band(1, 40'd20000));
    check("abort_idle", BW'(busy), '0);

    // Clean frame at re=2: 64 bins * 4 per band.
    run_frame(2, -1, 0, 0, 1'b0, all_bands(40'd256), 1'b0, 1'b0);
    wait_drain();

    // Reset in the middle of a frame.
    for (int i = 0; i <= 300; i++) drive(i, 1, 0);
    check("busy_mid_frame", BW'(busy), BW'(1'b1));
    #1;
    rst_n  = 1'b0;
    fif.dv = 1'b0;
    #1;
    check("reset_mid_bands", band_energy, '0);
    check("reset_mid_busy", BW'(busy), '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(1, -1, 0, 0, 1'b0, all_bands(40'd64), 1'b0, 1'b0);
    wait_drain();

    // Same frame with random 1-3 cycle dv gaps.
    run_frame(1, -1, 0, 0, 1'b1, all_bands(40'd64), 1'b0, 1'b0);
    wait_drain();

    // Beat detector: four frames with band0=1000 (30^2+10^2), then 5000 (70^2+10^2).
    do_reset();
    for (int f = 0; f < 5; f++) begin
      logic exp_b;
`ifdef BEAT_DETECT_EN
      exp_b = (f == 4);
`else
      exp_b = 1'b0;
`endif
      if (f == 4) run_frame(0, 1, 70, 10, 1'b0, one_band(0, 40'd5000), 1'b1, exp_b);
      else        run_frame(0, 1, 30, 10, 1'b0, one_band(0, 40'd1000), 1'b1, exp_b);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
